serdes_lane_engine: RTL
=======================

SERDES_LANE_ENGINE -- requirements
Module: serdes_lane_engine

Interface
REQ-001 Parameter: WIDTH, 8, bits per word per lane; WIDTH >= 2 SHALL be enforced by elaboration check.
REQ-002 Parameter: LANES, 4, number of parallel serial lanes; LANES >= 1.
REQ-003 Parameter: MSB_FIRST, 1, 1 = bit WIDTH-1 of each lane slice is sent first, 0 = bit 0 first.
REQ-004 Port: sclk  in  1  single clock; all logic on posedge; no derived or gated clocks.
REQ-005 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-006 Port: tx_data  in  LANES*WIDTH  parallel word; lane g uses tx_data[g*WIDTH +: WIDTH].
REQ-007 Port: tx_valid  in  1  tx_data valid.
REQ-008 Port: tx_ready  out  1  holding register empty (combinational = !hold_full).
REQ-009 Port: ser_out  out  LANES  registered serial data, one bit per lane.
REQ-010 Port: ser_sync  out  1  registered; high in the cycle carrying the first bit of each word.
REQ-011 Port: ser_in  in  LANES  serial data input.
REQ-012 Port: ser_sync_in  in  1  frame sync input; marks bit 0 of an incoming word.
REQ-013 Port: rx_data  out  LANES*WIDTH  registered deserialized word, same lane mapping as tx_data.
REQ-014 Port: rx_valid  out  1  one-cycle pulse; rx_data new.
REQ-015 Port: rx_error  out  1  one-cycle pulse on misaligned sync.

Function
REQ-016 Handshake SHALL be tx_valid && tx_ready sampled at posedge; that cycle is the accept cycle.
REQ-017 TX SHALL hold one word in a shifter plus one in a holding register.
REQ-018 Accept with shifter idle, or with shifter on its last bit and hold empty, SHALL load the shifter directly; otherwise the word SHALL go to the holding register.
REQ-019 On the shifter's last bit with hold full, hold SHALL move to the shifter and hold_full SHALL clear on that edge.
REQ-020 First bit SHALL appear on ser_out with ser_sync=1 in the cycle after loading; WIDTH consecutive bits per word; bit counter SHALL wrap WIDTH-1 -> 0.
REQ-021 Sustained streaming SHALL produce words with no idle cycle between them: ser_sync every WIDTH cycles.
REQ-022 TX idle (nothing loaded) SHALL drive ser_out=0 and ser_sync=0.
REQ-023 RX states: IDLE, COLLECT; ser_sync_in=1 in any state SHALL take the current ser_in as bit 0 and enter COLLECT with count=1.
REQ-024 In COLLECT, ser_in SHALL be shifted per lane in MSB_FIRST order; ser_in is ignored in IDLE.
REQ-025 On capture of bit WIDTH-1 the word SHALL register into rx_data and rx_valid SHALL pulse next cycle; RX returns to IDLE unless ser_sync_in is high that cycle.
REQ-026 ser_sync_in=1 with count in 1..WIDTH-1 SHALL discard the partial word, pulse rx_error next cycle, produce no rx_valid for it, and restart per REQ-023.
REQ-027 Loopback latency (ser_out->ser_in, ser_sync->ser_sync_in): accept in cycle 0 -> rx_valid in cycle WIDTH+1.
REQ-028 rx_data SHALL hold its value between rx_valid pulses.

Reset
REQ-029 reset_n low SHALL immediately force: ser_out=0, ser_sync=0, rx_data=0, rx_valid=0, rx_error=0, hold empty (tx_ready=1), shifter idle, RX IDLE, all counters 0.
REQ-030 Reset mid-word SHALL abandon TX and RX words; no rx_valid or rx_error for them after release.

Verification (WIDTH=8, LANES=4, loopback unless noted)
REQ-031 Reset: after reset_n low -> all outputs 0, tx_ready=1.
REQ-032 Single word 32'hA5C3_0FF0 accepted cycle 0 -> ser_sync high only in cycle 1; lane0 bits 1,1,1,1,0,0,0,0 in cycles 1-8; rx_valid in cycle 9 with rx_data=32'hA5C3_0FF0.
REQ-033 Three words, tx_valid held high -> accepted cycles 0,1,9; tx_ready low cycles 2-8 and 10-16; ser_sync in cycles 1,9,17; rx_valid in cycles 9,17,25 with matching data.
REQ-034 Misaligned sync, not loopback: sync_in at bit 0, extra sync_in at bit 3 -> rx_error one cycle, no rx_valid for the partial word; the next 8 bits are captured as one word.
REQ-035 reset_n low in cycle 4 of a word -> outputs 0 asynchronously; after release, no rx_valid until a new word is sent.
REQ-036 MSB_FIRST=0, lane0 = 8'hF0 -> lane0 bits 0,0,0,0,1,1,1,1; rx_data lane0 = 8'hF0.

Source files
------------

// File: rtl/serdes_lane_engine.sv
// serdes_lane_engine: multi-lane word serializer with one-word hold buffer and sync-framed deserializer.
module serdes_lane_engine #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   sclk,
  input  logic                   reset_n,
  input  logic [LANES*WIDTH-1:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [LANES-1:0]       ser_out,
  output logic                   ser_sync,
  input  logic [LANES-1:0]       ser_in,
  input  logic                   ser_sync_in,
  output logic [LANES*WIDTH-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   rx_error
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  if (WIDTH < 2 || LANES < 1) begin : g_bad_params
    $error("serdes_lane_engine: WIDTH must be >= 2 and LANES >= 1");
  end
  typedef enum logic {IDLE, COLLECT} rx_state_t;
  logic [LANES*WIDTH-1:0] sh, hold, src, rsh, rsh_nxt;
  logic [LANES-1:0] nbit;
  logic [CW-1:0] tcnt, idx, pos, rcnt;
  logic hold_full, busy, last, accept, load_new, load_hold, load, run;
  rx_state_t rx_state;
  assign tx_ready  = !hold_full;
  assign accept    = tx_valid && tx_ready;
  assign last      = busy && tcnt == LAST;
  assign load_new  = accept && (!busy || last);
  assign load_hold = last && hold_full;
  assign load      = load_new || load_hold;
  assign run       = load || (busy && !last);
  assign src       = load_new ? tx_data : load_hold ? hold : sh;
  // ser_out is registered, so it is loaded with the bit that goes out next cycle
  assign idx       = load ? '0 : tcnt + 1'b1;
  assign pos       = MSB_FIRST ? LAST - idx : idx;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [WIDTH-1:0] tw, rw;
    assign tw = src[g*WIDTH +: WIDTH];
    assign nbit[g] = tw[pos];
    assign rw = rsh[g*WIDTH +: WIDTH];
    assign rsh_nxt[g*WIDTH +: WIDTH] = MSB_FIRST ? {rw[WIDTH-2:0], ser_in[g]} : {ser_in[g], rw[WIDTH-1:1]};
  end
  always_ff @(posedge sclk or negedge reset_n)
    if (!reset_n) begin
      sh        <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      busy      <= 1'b0;
      tcnt      <= '0;
      ser_out   <= '0;
      ser_sync  <= 1'b0;
    end else begin
      if (accept && !load_new) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end else if (load_hold)
        hold_full <= 1'b0;
      sh       <= src;
      busy     <= run;
      tcnt     <= (busy && !last) ? tcnt + 1'b1 : '0;
      ser_out  <= run ? nbit : '0;
      ser_sync <= load;
    end
  // Sync always wins: a sync during a partial word drops it and restarts at bit 0
  always_ff @(posedge sclk or negedge reset_n)
    if (!reset_n) begin
      rx_state <= IDLE;
      rcnt     <= '0;
      rsh      <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      if (ser_sync_in) begin
        rx_error <= rx_state == COLLECT;
        rx_state <= COLLECT;
        rcnt     <= CW'(1);
        rsh      <= rsh_nxt;
      end else if (rx_state == COLLECT) begin
        rsh <= rsh_nxt;
        if (rcnt == LAST) begin
          rx_data  <= rsh_nxt;
          rx_valid <= 1'b1;
          rx_state <= IDLE;
          rcnt     <= '0;
        end else
          rcnt <= rcnt + 1'b1;
      end
    end
endmodule
